// File: rtl/led_trail_pkg.sv
// Shared constants and arithmetic helpers for the LED trail PWM block.
package led_trail_pkg;

  // Width of the saturating sweep counter.
  localparam int SWEEP_W = 16;

  // Full-brightness level for a given level width.
  function automatic int max_level(input int pw);
    return (32'sd1 << pw) - 32'sd1;
  endfunction

  // Subtract b from a, clamping at zero instead of wrapping.
  function automatic int sat_sub(input int a, input int b);
    if (a > b) begin
      return a - b;
    end else begin
      return 32'sd0;
    end
  endfunction

endpackage

// File: rtl/led_pwm_chan.sv
// One LED channel: brightness level with load/decay and registered PWM compare.
module led_pwm_chan
  import led_trail_pkg::*;
#(
  parameter int PW  = 4,
  parameter int DEC = 4
) (
  input  logic          clk_i,
  input  logic          rstna_i,
  input  logic          pos_i,
  input  logic          step_i,
  input  logic          out_en_i,
  input  logic [PW-1:0] pwm_cnt_i,
  output logic          led_o
);

  localparam logic [PW-1:0] MAX = PW'(max_level(PW));

  logic [PW-1:0] lvl_q, lvl_d;
  logic          led_q, led_d;

  // Lit channel reloads full brightness; unlit channels decay on each step.
  always_comb begin
    lvl_d = lvl_q;
    if (pos_i) begin
      lvl_d = MAX;
    end else if (step_i) begin
      lvl_d = PW'(sat_sub(int'(lvl_q), DEC));
    end else begin
      lvl_d = lvl_q;
    end
    led_d = out_en_i && (pwm_cnt_i < lvl_q);
  end

  // Level and LED drive registers.
  always_ff @(posedge clk_i or negedge rstna_i) begin
    if (!rstna_i) begin
      lvl_q <= '0;
      led_q <= 1'b0;
    end else begin
      lvl_q <= lvl_d;
      led_q <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_trail_pwm.sv
// Turns a bouncing one-hot position into N PWM-dimmed LEDs with a decaying
// trail, counts completed sweeps and flags malformed position vectors.
module led_trail_pwm
  import led_trail_pkg::*;
#(
  parameter int N   = 8,
  parameter int PW  = 4,
  parameter int DEC = 4
) (
  input  logic               clk,
  input  logic               rstna,
  input  logic [N-1:0]       pos,
  input  logic               step,
  input  logic               tc,
  input  logic               out_en,
  input  logic               sweep_clr,
  output logic [N-1:0]       led,
  output logic [SWEEP_W-1:0] sweeps,
  output logic               pos_err
);

  // Counter wraps after MAX-1 so the PWM period is MAX cycles.
  localparam logic [PW-1:0] PWM_LAST = PW'(max_level(PW) - 1);

  logic [PW-1:0]      pwm_cnt_q, pwm_cnt_d;
  logic [SWEEP_W-1:0] sweeps_q, sweeps_d;
  logic               pos_err_q, pos_err_d;

  // Next-state for the shared PWM counter, sweep counter and one-hot check.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q;
    if (pwm_cnt_q == PWM_LAST) begin
      pwm_cnt_d = '0;
    end else begin
      pwm_cnt_d = pwm_cnt_q + PW'(1);
    end

    sweeps_d = sweeps_q;
    if (sweep_clr) begin
      sweeps_d = '0;
    end else if (tc && (sweeps_q != {SWEEP_W{1'b1}})) begin
      sweeps_d = sweeps_q + SWEEP_W'(1);
    end else begin
      sweeps_d = sweeps_q;
    end

    // Zero, or a second set bit left after clearing the lowest one.
    pos_err_d = (pos == '0) || ((pos & (pos - N'(1))) != '0);
  end

  // Top-level state registers.
  always_ff @(posedge clk or negedge rstna) begin
    if (!rstna) begin
      pwm_cnt_q <= '0;
      sweeps_q  <= '0;
      pos_err_q <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      sweeps_q  <= sweeps_d;
      pos_err_q <= pos_err_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    led_pwm_chan #(
      .PW  (PW),
      .DEC (DEC)
    ) u_chan (
      .clk_i     (clk),
      .rstna_i   (rstna),
      .pos_i     (pos[i]),
      .step_i    (step),
      .out_en_i  (out_en),
      .pwm_cnt_i (pwm_cnt_q),
      .led_o     (led[i])
    );
  end

  assign sweeps  = sweeps_q;
  assign pos_err = pos_err_q;

endmodule
